// File: rtl/memory_access_stage.sv
// Memory access stage: issues loads/stores on a req/gnt/rvalid port and emits one write-back beat per operation.
// Optional misaligned-access trap is enabled by defining MEM_ACCESS_MISALIGN_TRAP_EN.
module memory_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_data,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_unsigned,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_timeout,
    output logic        wb_misalign
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Fields of the operation currently in flight
    logic       op_store_q, op_store_d;
    logic [1:0] op_size_q, op_size_d;
    logic       op_uns_q, op_uns_d;
    logic       op_rw_q, op_rw_d;
    logic [4:0] op_rd_q, op_rd_d;
    logic [1:0] op_off_q, op_off_d;

    logic        ex_ready_d;
    logic        dmem_req_d, dmem_we_d;
    logic [31:0] dmem_addr_d, dmem_wdata_d;
    logic [3:0]  dmem_be_d;
    logic        wb_valid_d, wb_reg_write_d, wb_timeout_d, wb_misalign_d;
    logic [4:0]  wb_rd_d;
    logic [31:0] wb_data_d;

    logic mem_op_c;
    logic misalign_c;

    assign mem_op_c = ex_mem_read | ex_mem_write;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign misalign_c = ((ex_mem_size == 2'd1) && ex_alu_data[0]) ||
                        (ex_mem_size[1] && (ex_alu_data[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_be = 4'b0001 << off;
            2'd1:    lane_be = off[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'd0:    lane_wdata = {4{data[7:0]}};
            2'd1:    lane_wdata = {2{data[15:0]}};
            default: lane_wdata = data;
        endcase
    endfunction

    // Select the addressed lane of the returned word and extend it to 32 bits
    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (size)
            2'd0:    load_extend = {{24{b[7] & ~uns}}, b};
            2'd1:    load_extend = {{16{h[15] & ~uns}}, h};
            default: load_extend = rdata;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_store_d     = op_store_q;
        op_size_d      = op_size_q;
        op_uns_d       = op_uns_q;
        op_rw_d        = op_rw_q;
        op_rd_d        = op_rd_q;
        op_off_d       = op_off_q;
        dmem_req_d     = 1'b0;
        dmem_we_d      = dmem_we;
        dmem_addr_d    = dmem_addr;
        dmem_wdata_d   = dmem_wdata;
        dmem_be_d      = dmem_be;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write;
        wb_rd_d        = wb_rd;
        wb_data_d      = wb_data;
        wb_timeout_d   = wb_timeout;
        wb_misalign_d  = wb_misalign;

        case (state_q)
            IDLE: begin
                if (ex_valid && ex_ready) begin
                    if (!mem_op_c) begin
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = ex_reg_write;
                        wb_rd_d        = ex_rd;
                        wb_data_d      = ex_alu_data;
                        wb_timeout_d   = 1'b0;
                        wb_misalign_d  = 1'b0;
                    end else if (misalign_c) begin
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = 1'b0;
                        wb_rd_d        = ex_rd;
                        wb_data_d      = '0;
                        wb_timeout_d   = 1'b0;
                        wb_misalign_d  = 1'b1;
                    end else begin
                        op_store_d   = ex_mem_write;
                        op_size_d    = ex_mem_size;
                        op_uns_d     = ex_mem_unsigned;
                        op_rw_d      = ex_reg_write;
                        op_rd_d      = ex_rd;
                        op_off_d     = ex_alu_data[1:0];
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = ex_mem_write;
                        dmem_addr_d  = {ex_alu_data[31:2], 2'b00};
                        dmem_wdata_d = lane_wdata(ex_mem_size, ex_store_data);
                        dmem_be_d    = lane_be(ex_mem_size, ex_alu_data[1:0]);
                        state_d      = REQ;
                    end
                end
            end
            REQ: begin
                dmem_req_d = ~dmem_gnt;
                if (dmem_gnt) begin
                    if (op_store_q) begin
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = 1'b0;
                        wb_rd_d        = op_rd_q;
                        wb_data_d      = '0;
                        wb_timeout_d   = 1'b0;
                        wb_misalign_d  = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // rvalid wins over a timeout landing in the same cycle
                if (dmem_rvalid) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = op_rw_q;
                    wb_rd_d        = op_rd_q;
                    wb_data_d      = load_extend(dmem_rdata, op_size_q, op_off_q, op_uns_q);
                    wb_timeout_d   = 1'b0;
                    wb_misalign_d  = 1'b0;
                    state_d        = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = 1'b0;
                    wb_rd_d        = op_rd_q;
                    wb_data_d      = '0;
                    wb_timeout_d   = 1'b1;
                    wb_misalign_d  = 1'b0;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        ex_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_store_q   <= 1'b0;
            op_size_q    <= 2'd0;
            op_uns_q     <= 1'b0;
            op_rw_q      <= 1'b0;
            op_rd_q      <= 5'd0;
            op_off_q     <= 2'd0;
            ex_ready     <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= 4'd0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= '0;
            wb_timeout   <= 1'b0;
            wb_misalign  <= 1'b0;
        end else begin
            op_store_q   <= op_store_d;
            op_size_q    <= op_size_d;
            op_uns_q     <= op_uns_d;
            op_rw_q      <= op_rw_d;
            op_rd_q      <= op_rd_d;
            op_off_q     <= op_off_d;
            ex_ready     <= ex_ready_d;
            dmem_req     <= dmem_req_d;
            dmem_we      <= dmem_we_d;
            dmem_addr    <= dmem_addr_d;
            dmem_wdata   <= dmem_wdata_d;
            dmem_be      <= dmem_be_d;
            wb_valid     <= wb_valid_d;
            wb_reg_write <= wb_reg_write_d;
            wb_rd        <= wb_rd_d;
            wb_data      <= wb_data_d;
            wb_timeout   <= wb_timeout_d;
            wb_misalign  <= wb_misalign_d;
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Testbench for memory_access_stage: directed vector table, hand sequences and randomized ops vs. a lane model.
module tb_memory_access_stage;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_alu_data, ex_store_data;
    logic        ex_mem_read, ex_mem_write;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_unsigned, ex_reg_write;
    logic [4:0]  ex_rd;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_timeout, wb_misalign;

    int total = 0;
    int bad = 0;

    memory_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_data(ex_alu_data), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_timeout(wb_timeout), .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;      // 0 = ALU, 1 = store, 2 = load
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [1:0]  size;
        logic        uns;
        logic        rw;
        logic [4:0]  rd;
        int          gnt_dly;
        int          rv_dly;    // > T means never answer
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic [31:0] addr, input logic uns);
        int          sh;
        int          w;
        logic [31:0] v;
        logic [31:0] mask;
        if (size == 2'd0) begin
            sh = 8 * int'(addr[1:0]); w = 8;
        end else if (size == 2'd1) begin
            sh = 16 * int'(addr[1]); w = 16;
        end else begin
            sh = 0; w = 32;
        end
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        v = (rdata >> sh) & mask;
        if (w < 32 && !uns && v[w-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd0) return 4'(1 << addr[1:0]);
        if (size == 2'd1) return 4'(3 << (2 * int'(addr[1])));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'd0) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (size == 2'd1) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic is_misaligned(input vec_t v);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        if (v.kind == 0) return 1'b0;
        return (v.size == 2'd1 && v.alu[0]) || (v.size >= 2'd2 && v.alu[1:0] != 2'b00);
`else
        return (v.kind < 0);
`endif
    endfunction

    // Drive one operation through accept, handshake and write-back, checking each step
    task automatic run_op(input vec_t v);
        logic mis;
        mis = is_misaligned(v);
        chk("ready_before_issue", 32'(ex_ready), 32'd1);
        ex_valid        = 1'b1;
        ex_alu_data     = v.alu;
        ex_store_data   = v.sdata;
        ex_mem_write    = (v.kind == 1);
        ex_mem_read     = (v.kind == 2);
        ex_mem_size     = v.size;
        ex_mem_unsigned = v.uns;
        ex_reg_write    = v.rw;
        ex_rd           = v.rd;
        tick();
        ex_valid     = 1'b0;
        ex_mem_write = 1'b0;
        ex_mem_read  = 1'b0;
        if (v.kind == 0 || mis) begin
            chk("imm_wb_valid", 32'(wb_valid), 32'd1);
            chk("imm_wb_misalign", 32'(wb_misalign), 32'(mis));
            chk("imm_wb_reg_write", 32'(wb_reg_write), mis ? 32'd0 : 32'(v.rw));
            chk("imm_wb_rd", 32'(wb_rd), 32'(v.rd));
            if (!mis) chk("alu_wb_data", wb_data, v.exp_data);
            chk("imm_no_req", 32'(dmem_req), 32'd0);
            chk("imm_ready", 32'(ex_ready), 32'd1);
        end else begin
            chk("req_asserted", 32'(dmem_req), 32'd1);
            chk("req_addr", dmem_addr, {v.alu[31:2], 2'b00});
            chk("req_we", 32'(dmem_we), 32'(v.kind == 1));
            chk("req_be", 32'(dmem_be), 32'(v.exp_be));
            if (v.kind == 1) chk("req_wdata", dmem_wdata, v.exp_wdata);
            chk("ready_low_in_req", 32'(ex_ready), 32'd0);
            for (int i = 0; i < v.gnt_dly; i++) begin
                tick();
                chk("req_held", 32'(dmem_req), 32'd1);
                chk("addr_held", dmem_addr, {v.alu[31:2], 2'b00});
            end
            dmem_gnt = 1'b1;
            tick();
            dmem_gnt = 1'b0;
            chk("req_dropped", 32'(dmem_req), 32'd0);
            if (v.kind == 1) begin
                chk("st_wb_valid", 32'(wb_valid), 32'd1);
                chk("st_wb_reg_write", 32'(wb_reg_write), 32'd0);
                chk("st_wb_rd", 32'(wb_rd), 32'(v.rd));
                chk("st_ready", 32'(ex_ready), 32'd1);
            end else begin
                chk("ld_wait_no_wb", 32'(wb_valid), 32'd0);
                if (v.rv_dly <= T) begin
                    for (int i = 0; i < v.rv_dly; i++) tick();
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = v.rdata;
                    tick();
                    dmem_rvalid = 1'b0;
                    dmem_rdata  = $urandom;
                    chk("ld_wb_valid", 32'(wb_valid), 32'd1);
                    chk("ld_wb_timeout", 32'(wb_timeout), 32'd0);
                    chk("ld_wb_data", wb_data, v.exp_data);
                    chk("ld_wb_reg_write", 32'(wb_reg_write), 32'(v.rw));
                    chk("ld_wb_rd", 32'(wb_rd), 32'(v.rd));
                    chk("ld_ready", 32'(ex_ready), 32'd1);
                end else begin
                    for (int i = 0; i < T; i++) tick();
                    chk("to_not_early", 32'(wb_valid), 32'd0);
                    chk("to_ready_low", 32'(ex_ready), 32'd0);
                    tick();
                    chk("to_wb_valid", 32'(wb_valid), 32'd1);
                    chk("to_wb_timeout", 32'(wb_timeout), 32'd1);
                    chk("to_wb_data", wb_data, 32'd0);
                    chk("to_wb_reg_write", 32'(wb_reg_write), 32'd0);
                end
            end
        end
        tick();
        chk("wb_single_pulse", 32'(wb_valid), 32'd0);
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_alu_data = '0; ex_store_data = '0;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_size = 2'd0;
        ex_mem_unsigned = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        //        kind alu            sdata          rdata          sz uns rw rd  gd rv  exp_data       be       wdata
        tbl[0] = '{0, 32'h0000_1234, 32'h0,        32'h0,         2'd0, 1'b0, 1'b1, 5'd5,  0, 0,  32'h0000_1234, 4'h0, 32'h0};
        tbl[1] = '{1, 32'h0000_0102, 32'h0000_00A5, 32'h0,        2'd0, 1'b0, 1'b1, 5'd6,  1, 0,  32'h0,         4'b0100, 32'hA5A5_A5A5};
        tbl[2] = '{2, 32'h0000_0202, 32'h0,        32'h8001_7FFF, 2'd1, 1'b0, 1'b1, 5'd7,  0, 2,  32'hFFFF_8001, 4'b1100, 32'h0};
        tbl[3] = '{2, 32'h0000_0202, 32'h0,        32'h8001_7FFF, 2'd1, 1'b1, 1'b1, 5'd8,  0, 2,  32'h0000_8001, 4'b1100, 32'h0};
        tbl[4] = '{2, 32'h0000_0203, 32'h0,        32'hDEAD_BEEF, 2'd2, 1'b0, 1'b1, 5'd9,  0, 0,  32'hDEAD_BEEF, 4'b1111, 32'h0};
        tbl[5] = '{2, 32'h0000_0301, 32'h0,        32'h1234_80FF, 2'd0, 1'b0, 1'b1, 5'd10, 2, 1,  32'hFFFF_FF80, 4'b0010, 32'h0};
        tbl[6] = '{1, 32'h0000_0406, 32'h1234_BEEF, 32'h0,        2'd1, 1'b0, 1'b1, 5'd11, 0, 0,  32'h0,         4'b1100, 32'hBEEF_BEEF};
        tbl[7] = '{2, 32'h0000_0500, 32'h0,        32'h8000_0001, 2'd3, 1'b1, 1'b1, 5'd12, 0, 0,  32'h8000_0001, 4'b1111, 32'h0};
        tbl[8] = '{2, 32'h0000_0600, 32'h0,        32'h0,         2'd2, 1'b0, 1'b1, 5'd13, 0, 99, 32'h0,         4'b1111, 32'h0};

        // Reset values
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_ex_ready", 32'(ex_ready), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("ready_after_release", 32'(ex_ready), 32'd1);

        for (int i = 0; i < 9; i++) run_op(tbl[i]);

        // A late rvalid after a timeout must be ignored
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
        tick();
        dmem_rvalid = 1'b0;
        chk("late_rvalid_ignored", 32'(wb_valid), 32'd0);
        chk("late_rvalid_no_req", 32'(dmem_req), 32'd0);

        // Back-to-back ALU ops, one per cycle
        ex_valid = 1'b1; ex_reg_write = 1'b1;
        ex_alu_data = 32'h1111_0001; ex_rd = 5'd1;
        tick();
        chk("b2b_first_valid", 32'(wb_valid), 32'd1);
        chk("b2b_first_data", wb_data, 32'h1111_0001);
        ex_alu_data = 32'h2222_0002; ex_rd = 5'd2;
        tick();
        ex_valid = 1'b0;
        chk("b2b_second_valid", 32'(wb_valid), 32'd1);
        chk("b2b_second_data", wb_data, 32'h2222_0002);
        chk("b2b_second_rd", 32'(wb_rd), 32'd2);
        tick();

        // Reset while a load waits for data
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_size = 2'd2;
        ex_alu_data = 32'h0000_0700; ex_rd = 5'd3;
        tick();
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_wait_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wait_ready", 32'(ex_ready), 32'd0);
        chk("rst_wait_addr", dmem_addr, 32'd0);
        tick();
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_rvalid = 1'b0;
        chk("rst_late_rvalid", 32'(wb_valid), 32'd0);
        chk("rst_ready_back", 32'(ex_ready), 32'd1);
        tick();
        chk("rst_still_quiet", 32'(wb_valid), 32'd0);

        // Randomized operations against the lane model
        for (int n = 0; n < 80; n++) begin
            rv.kind    = int'($urandom % 3);
            rv.alu     = $urandom;
            rv.sdata   = $urandom;
            rv.rdata   = $urandom;
            rv.size    = 2'($urandom);
            rv.uns     = 1'($urandom);
            rv.rw      = 1'($urandom);
            rv.rd      = 5'($urandom);
            rv.gnt_dly = int'($urandom % 3);
            rv.rv_dly  = ($urandom % 10 == 0) ? 99 : int'($urandom % 5);
            rv.exp_be    = model_be(rv.size, rv.alu);
            rv.exp_wdata = model_wdata(rv.size, rv.sdata);
            if (rv.kind == 0)       rv.exp_data = rv.alu;
            else if (rv.rv_dly > T) rv.exp_data = 32'd0;
            else                    rv.exp_data = model_load(rv.rdata, rv.size, rv.alu, rv.uns);
            run_op(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
